// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and lane helpers.
// The build macro LSU_MISALIGN_EXC_EN only affects how these helpers are used by mem_access_unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  // Unused encodings (011/110/111) fall through to word accesses.
  function automatic lsu_size_e access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of an SRAM word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] sram_dout_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        isSigned;

  always_comb begin
    byteSel  = sram_dout_i[{addr_lo_i, 3'b000} +: 8];
    halfSel  = addr_lo_i[1] ? sram_dout_i[31:16] : sram_dout_i[15:0];
    isSigned = (funct3_i == F3_B) || (funct3_i == F3_H);
    rdata_o  = sram_dout_i;
    case (access_size(funct3_i))
      SZ_BYTE: rdata_o = {{24{isSigned & byteSel[7]}}, byteSel};
      SZ_HALF: rdata_o = {{16{isSigned & halfSel[15]}}, halfSel};
      default: rdata_o = sram_dout_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a word-addressed SRAM with byte-lane enables.
// Define LSU_MISALIGN_EXC_EN to suppress misaligned accesses and flag them on resp_err.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  lsu_state_e            state_q, state_d;
  logic                  opIsLoad_q, opIsLoad_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addrLo_q, addrLo_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] holdRdata_q, holdRdata_d;
  logic                  holdErr_q, holdErr_d;

  logic                  fire;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] alignedRdata;
  logic [DATA_WIDTH-1:0] liveRdata;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // A new request can be taken whenever the current response leaves this cycle.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      req_ready = (state_q == IDLE) ? 1'b1 : resp_ready;
    end
  end

  assign fire = req_valid && req_ready && !rst;

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 4'b0000;
    sram_addr = req_addr[ADDR_WIDTH+1:2];
    case (access_size(req_funct3))
      SZ_BYTE: sram_din = {4{req_wdata[7:0]}};
      SZ_HALF: sram_din = {2{req_wdata[15:0]}};
      default: sram_din = req_wdata;
    endcase
    if (fire && !misaligned) begin
      sram_en = 1'b1;
      if (req_we) begin
        sram_we = byte_mask(req_funct3, req_addr[1:0]);
      end
    end
  end

  lsu_load_align u_load_align (
    .sram_dout_i (sram_dout),
    .funct3_i    (funct3_q),
    .addr_lo_i   (addrLo_q),
    .rdata_o     (alignedRdata)
  );

  // SRAM dout is only valid in the cycle right after the access, so stalled data goes to hold regs.
  assign liveRdata = (opIsLoad_q && !err_q) ? alignedRdata : '0;

  always_comb begin
    state_d     = state_q;
    opIsLoad_d  = opIsLoad_q;
    funct3_d    = funct3_q;
    addrLo_d    = addrLo_q;
    err_d       = err_q;
    holdRdata_d = holdRdata_q;
    holdErr_d   = holdErr_q;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;

    if (fire) begin
      opIsLoad_d = !req_we;
      funct3_d   = req_funct3;
      addrLo_d   = req_addr[1:0];
      err_d      = misaligned;
    end

    case (state_q)
      IDLE: begin
        if (fire) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = liveRdata;
        resp_err   = err_q;
        if (resp_ready) begin
          state_d = fire ? RESP : IDLE;
        end else begin
          holdRdata_d = liveRdata;
          holdErr_d   = err_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        resp_valid = 1'b1;
        resp_rdata = holdRdata_q;
        resp_err   = holdErr_q;
        if (resp_ready) state_d = fire ? RESP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opIsLoad_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addrLo_q    <= 2'b00;
      err_q       <= 1'b0;
      holdRdata_q <= '0;
      holdErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opIsLoad_q  <= opIsLoad_d;
      funct3_q    <= funct3_d;
      addrLo_q    <= addrLo_d;
      err_q       <= err_d;
      holdRdata_q <= holdRdata_d;
      holdErr_q   <= holdErr_d;
    end
  end

endmodule
